// File: rtl/i2c_reg_master.sv
// -----------------------------------------------------------------------------
// i2c_reg_master
//
// Single-clock I2C initiator for the register-map I2C target. A one-shot
// command performs either a register write (dev+W, reg, data) or a register
// read (dev+W, reg, Sr, dev+R, data, master NACK). SCL and SDA are driven as
// open-drain enables: 1 pulls the line low, 0 releases it to the pull-up.
//
// Parameters
//   CLK_DIV    clk cycles per SCL quarter period (1..1023); SCL = 4*CLK_DIV
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  start request, sampled only while busy=0
//   cmd_rw     0 = register write, 1 = register read
//   cmd_dev    7-bit target address
//   cmd_reg    register address
//   cmd_wdata  write data (ignored on reads)
//   busy       transaction in progress
//   done       one-cycle pulse on the last busy cycle
//   ack_err    a target ACK was missing (valid with done, held until the
//              next accepted command)
//   rd_data    last byte read by an error-free read
//   scl_oe     1 = pull SCL low
//   sda_oe     1 = pull SDA low
//   sda_in     synchronized SDA pad level
// -----------------------------------------------------------------------------
module i2c_reg_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_TXBIT  = 3'd2,
    ST_TXACK  = 3'd3,
    ST_RSTART = 3'd4,
    ST_RXBIT  = 3'd5,
    ST_MNACK  = 3'd6,
    ST_STOP   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  div_q, div_d;       // clk count inside the current quarter
  logic [1:0]  qtr_q, qtr_d;       // quarter q0..q3 inside the current phase
  logic [2:0]  bit_q, bit_d;       // bit index, 7 down to 0
  logic [1:0]  idx_q, idx_d;       // byte index 0..2
  logic        rw_q, rw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  radr_q, radr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rx_q, rx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ack_err_q, ack_err_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;

  logic        phase_end_s;
  logic        sample_s;
  logic [7:0]  tx_byte_s;
  logic [1:0]  drive_s;

  // Byte transmitted in a given byte slot.
  function automatic logic [7:0] tx_byte(input logic [1:0] idx, input logic rw,
                                         input logic [6:0] dev, input logic [7:0] radr,
                                         input logic [7:0] wdata);
    logic [7:0] b;
    case (idx)
      2'd0:    b = {dev, 1'b0};
      2'd1:    b = radr;
      2'd2:    b = rw ? {dev, 1'b1} : wdata;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Line drive {scl_oe, sda_oe} for a given phase and quarter.
  function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] qtr,
                                            input logic tx_bit);
    logic [1:0] drv;
    case (st)
      ST_START:  drv = qtr[1] ? 2'b01 : 2'b00;
      ST_RSTART: begin
        case (qtr)
          2'd0:    drv = 2'b10;
          2'd1:    drv = 2'b00;
          default: drv = 2'b01;
        endcase
      end
      ST_TXBIT:  drv = {~qtr[1], ~tx_bit};
      ST_TXACK,
      ST_RXBIT,
      ST_MNACK:  drv = {~qtr[1], 1'b0};
      ST_STOP: begin
        case (qtr)
          2'd0:    drv = 2'b11;
          2'd1:    drv = 2'b01;
          default: drv = 2'b00;
        endcase
      end
      default:   drv = 2'b00;
    endcase
    return drv;
  endfunction

  // Next-state, quarter timing and next values of all registered outputs.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    idx_d     = idx_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    radr_d    = radr_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    ack_err_d = ack_err_q;
    rd_data_d = rd_data_q;

    phase_end_s = (qtr_q == 2'd3) && (div_q == DIV_LAST);
    sample_s    = (qtr_q == 2'd2) && (div_q == DIV_LAST);

    // Quarter counter: free-runs while a transaction is active, and the
    // q3 -> q0 wrap coincides with every phase boundary.
    if (state_q == ST_IDLE) begin
      div_d = 10'd0;
      qtr_d = 2'd0;
    end else if (div_q == DIV_LAST) begin
      div_d = 10'd0;
      qtr_d = qtr_q + 2'd1;
    end else begin
      div_d = div_q + 10'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          rw_d      = cmd_rw;
          dev_d     = cmd_dev;
          radr_d    = cmd_reg;
          wdata_d   = cmd_wdata;
          ack_err_d = 1'b0;
          state_d   = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (phase_end_s) begin
          state_d = ST_TXBIT;
          idx_d   = 2'd0;
          bit_d   = 3'd7;
        end else begin
          state_d = ST_START;
        end
      end
      ST_TXBIT: begin
        if (phase_end_s) begin
          if (bit_q == 3'd0) begin
            state_d = ST_TXACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end else begin
          state_d = ST_TXBIT;
        end
      end
      ST_TXACK: begin
        // ack_err is cleared at command acceptance, so a set flag here means
        // this slot was NACKed; by phase end the q2 sample has landed.
        if (sample_s && sda_in) begin
          ack_err_d = 1'b1;
        end else begin
          ack_err_d = ack_err_q;
        end
        if (phase_end_s) begin
          bit_d = 3'd7;
          if (ack_err_q) begin
            state_d = ST_STOP;
          end else if (idx_q == 2'd0) begin
            idx_d   = 2'd1;
            state_d = ST_TXBIT;
          end else if (idx_q == 2'd1) begin
            idx_d   = 2'd2;
            state_d = rw_q ? ST_RSTART : ST_TXBIT;
          end else begin
            state_d = rw_q ? ST_RXBIT : ST_STOP;
          end
        end else begin
          state_d = ST_TXACK;
        end
      end
      ST_RSTART: begin
        if (phase_end_s) begin
          state_d = ST_TXBIT;
          bit_d   = 3'd7;
        end else begin
          state_d = ST_RSTART;
        end
      end
      ST_RXBIT: begin
        if (sample_s) begin
          rx_d = {rx_q[6:0], sda_in};
        end else begin
          rx_d = rx_q;
        end
        if (phase_end_s) begin
          if (bit_q == 3'd0) begin
            state_d = ST_MNACK;
          end else begin
            bit_d = bit_q - 3'd1;
          end
        end else begin
          state_d = ST_RXBIT;
        end
      end
      ST_MNACK: begin
        if (phase_end_s) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_MNACK;
        end
      end
      ST_STOP: begin
        if (phase_end_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state: the
    // registered value then lines up exactly with the cycle it describes.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_STOP) && (qtr_d == 2'd3) && (div_d == DIV_LAST);
    if (done_d && rw_q && !ack_err_q) begin
      rd_data_d = rx_q;
    end else begin
      rd_data_d = rd_data_q;
    end

    tx_byte_s = tx_byte(idx_d, rw_d, dev_d, radr_d, wdata_d);
    drive_s   = line_drive(state_d, qtr_d, tx_byte_s[bit_d]);
    scl_oe_d  = drive_s[1];
    sda_oe_d  = drive_s[0];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= 10'd0;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd7;
      idx_q     <= 2'd0;
      rw_q      <= 1'b0;
      dev_q     <= 7'h00;
      radr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      rx_q      <= 8'h00;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      rd_data_q <= 8'h00;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      radr_q    <= radr_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      rd_data_q <= rd_data_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign rd_data = rd_data_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_i2c_reg_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_reg_master
//
// Two initiators share one open-drain bus: dut0 (CLK_DIV=4) and dut1
// (CLK_DIV=1). A behavioural register-map target watches the wired bus,
// logs START / STOP / bytes / master ACK-NACK, ACKs its own address, can
// NACK a chosen data byte, and returns a programmed byte on reads.
// -----------------------------------------------------------------------------
module tb_i2c_reg_master;

  localparam int EV_S    = 256;
  localparam int EV_P    = 257;
  localparam int EV_NACK = 258;
  localparam int EV_ACK  = 259;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid0 = 1'b0;
  logic       cmd_valid1 = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_dev = 7'h00;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       sel = 1'b0;

  logic       busy0, done0, ack_err0, scl_oe0, sda_oe0;
  logic       busy1, done1, ack_err1, scl_oe1, sda_oe1;
  logic [7:0] rd_data0, rd_data1;
  logic       sda_line;

  logic       busy_m, done_m, ack_err_m, scl_oe_m, sda_oe_m;
  logic [7:0] rd_data_m;

  // target model state
  logic       tgt_oe = 1'b0;
  logic       scl_prev = 1'b1, msda_prev = 1'b1;
  logic       scl_now, msda_now, sda_now;
  logic       ignore = 1'b1, is_addr = 1'b0, tx = 1'b0, ack_ok = 1'b0, rd_mode = 1'b0;
  int         bcnt = 0;
  int         nbytes = 0;
  int         nack_byte = -1;
  logic [7:0] sh = 8'h00;
  logic [7:0] tgt_rdata = 8'h00;
  int         ev_q[$];

  int nerr = 0;
  int nchk = 0;

  assign sda_line  = ~(sda_oe0 | sda_oe1 | tgt_oe);
  assign busy_m    = sel ? busy1    : busy0;
  assign done_m    = sel ? done1    : done0;
  assign ack_err_m = sel ? ack_err1 : ack_err0;
  assign rd_data_m = sel ? rd_data1 : rd_data0;
  assign scl_oe_m  = sel ? scl_oe1  : scl_oe0;
  assign sda_oe_m  = sel ? sda_oe1  : sda_oe0;

  i2c_reg_master #(.CLK_DIV(4)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid0), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .busy(busy0), .done(done0), .ack_err(ack_err0), .rd_data(rd_data0),
    .scl_oe(scl_oe0), .sda_oe(sda_oe0), .sda_in(sda_line)
  );

  i2c_reg_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .busy(busy1), .done(done1), .ack_err(ack_err1), .rd_data(rd_data1),
    .scl_oe(scl_oe1), .sda_oe(sda_oe1), .sda_in(sda_line)
  );

  always #5 clk = ~clk;

  // Behavioural I2C target evaluated on the falling clk edge.
  always @(negedge clk) begin
    scl_now  = ~(scl_oe0 | scl_oe1);
    msda_now = ~(sda_oe0 | sda_oe1);
    sda_now  = msda_now & ~tgt_oe;
    if (scl_prev && scl_now && msda_prev && !msda_now) begin
      ev_q.push_back(EV_S);
      bcnt = 0; tx = 1'b0; tgt_oe = 1'b0; ignore = 1'b0; is_addr = 1'b1; nbytes = 0;
    end else if (scl_prev && scl_now && !msda_prev && msda_now) begin
      ev_q.push_back(EV_P);
      bcnt = 0; tx = 1'b0; tgt_oe = 1'b0; ignore = 1'b1;
    end else if (!ignore && !scl_prev && scl_now) begin
      if (bcnt < 8) begin
        if (!tx) sh = {sh[6:0], sda_now};
        bcnt++;
        if (bcnt == 8 && !tx) begin
          ev_q.push_back(int'(sh));
          if (is_addr) begin
            ack_ok  = (sh[7:1] == 7'h5A);
            rd_mode = sh[0];
          end else begin
            ack_ok = (nbytes != nack_byte);
          end
          is_addr = 1'b0;
          nbytes++;
        end
      end else begin
        if (tx) begin
          ev_q.push_back(sda_now ? EV_NACK : EV_ACK);
          tx = 1'b0; ignore = 1'b1;
        end else if (!ack_ok) begin
          ignore = 1'b1;
        end else if (rd_mode) begin
          tx = 1'b1;
        end
        bcnt = 0;
      end
    end else if (!ignore && scl_prev && !scl_now) begin
      if (bcnt == 8) tgt_oe = !tx && ack_ok;
      else if (tx)   tgt_oe = ~tgt_rdata[7 - bcnt];
      else           tgt_oe = 1'b0;
    end
    scl_prev  = scl_now;
    msda_prev = msda_now;
  end

  typedef struct {
    logic       sel;
    logic       rw;
    logic [6:0] dev;
    logic [7:0] radr;
    logic [7:0] wdata;
    logic [7:0] tdata;
    int         nack_byte;
    int         glitch_at;
    int         exp_cycles;
    logic       exp_err;
    logic [7:0] exp_rd;
    int         nev;
  } vec_t;

  vec_t vecs[7];
  int   exp_ev[7][8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command at the current negedge and follow it to completion.
  task automatic run_vec(input int i);
    vec_t v;
    int   cyc, done_at, ndone;
    logic err_at_done;
    v = vecs[i];
    sel       = v.sel;
    nack_byte = v.nack_byte;
    tgt_rdata = v.tdata;
    ev_q.delete();
    cmd_rw = v.rw; cmd_dev = v.dev; cmd_reg = v.radr; cmd_wdata = v.wdata;
    if (v.sel) cmd_valid1 = 1'b1; else cmd_valid0 = 1'b1;
    @(negedge clk);
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    check($sformatf("v%0d busy_rise", i), busy_m, 1'b1);
    check($sformatf("v%0d ack_err_clr", i), ack_err_m, 1'b0);
    cyc = 0; done_at = 0; ndone = 0; err_at_done = 1'bx;
    while (busy_m && cyc < 2000) begin
      cyc++;
      if (done_m) begin
        ndone++; done_at = cyc; err_at_done = ack_err_m;
      end
      if (cyc == v.glitch_at) begin
        cmd_rw = ~v.rw; cmd_dev = 7'h11; cmd_reg = 8'hEE; cmd_wdata = 8'h00;
        if (v.sel) cmd_valid1 = 1'b1; else cmd_valid0 = 1'b1;
      end else begin
        cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    check($sformatf("v%0d busy_len", i), cyc, v.exp_cycles);
    check($sformatf("v%0d done_count", i), ndone, 1);
    check($sformatf("v%0d done_pos", i), done_at, v.exp_cycles);
    check($sformatf("v%0d done_low_after", i), done_m, 1'b0);
    check($sformatf("v%0d ack_err", i), err_at_done, v.exp_err);
    check($sformatf("v%0d ack_err_hold", i), ack_err_m, v.exp_err);
    check($sformatf("v%0d rd_data", i), rd_data_m, v.exp_rd);
    check($sformatf("v%0d ev_count", i), ev_q.size(), v.nev);
    for (int k = 0; k < v.nev; k++) begin
      if (k < ev_q.size()) check($sformatf("v%0d ev%0d", i, k), ev_q[k], exp_ev[i][k]);
      else                 check($sformatf("v%0d ev%0d", i, k), 32'hFFFF, exp_ev[i][k]);
    end
  endtask

  initial begin
    int ndone;
    //          sel   rw    dev    reg    wdata  tdata  nack glt  cyc  err   rd     nev
    vecs[0] = '{1'b0, 1'b0, 7'h5A, 8'h03, 8'hC5, 8'h00, -1, 100, 464, 1'b0, 8'h00, 5};
    vecs[1] = '{1'b0, 1'b1, 7'h5A, 8'h10, 8'h00, 8'h3C, -1,   0, 624, 1'b0, 8'h3C, 7};
    vecs[2] = '{1'b0, 1'b0, 7'h11, 8'h00, 8'h00, 8'h00, -1,   0, 176, 1'b1, 8'h3C, 3};
    vecs[3] = '{1'b0, 1'b0, 7'h5A, 8'h07, 8'h81, 8'h00,  2,   0, 464, 1'b1, 8'h3C, 5};
    vecs[4] = '{1'b0, 1'b1, 7'h5A, 8'h20, 8'h00, 8'hA5, -1, 300, 624, 1'b0, 8'hA5, 7};
    vecs[5] = '{1'b0, 1'b1, 7'h12, 8'h55, 8'h00, 8'h00, -1,   0, 176, 1'b1, 8'hA5, 3};
    vecs[6] = '{1'b1, 1'b0, 7'h5A, 8'h44, 8'h9E, 8'h00, -1,   0, 116, 1'b0, 8'h00, 5};
    exp_ev[0] = '{EV_S, 32'hB4, 32'h03, 32'hC5, EV_P, 0, 0, 0};
    exp_ev[1] = '{EV_S, 32'hB4, 32'h10, EV_S, 32'hB5, EV_NACK, EV_P, 0};
    exp_ev[2] = '{EV_S, 32'h22, EV_P, 0, 0, 0, 0, 0};
    exp_ev[3] = '{EV_S, 32'hB4, 32'h07, 32'h81, EV_P, 0, 0, 0};
    exp_ev[4] = '{EV_S, 32'hB4, 32'h20, EV_S, 32'hB5, EV_NACK, EV_P, 0};
    exp_ev[5] = '{EV_S, 32'h24, EV_P, 0, 0, 0, 0, 0};
    exp_ev[6] = '{EV_S, 32'hB4, 32'h44, 32'h9E, EV_P, 0, 0, 0};

    // reset values
    repeat (3) @(negedge clk);
    check("rst scl_oe", scl_oe0, 1'b0);
    check("rst sda_oe", sda_oe0, 1'b0);
    check("rst busy", busy0, 1'b0);
    check("rst done", done0, 1'b0);
    check("rst ack_err", ack_err0, 1'b0);
    check("rst rd_data", rd_data0, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // table vectors, issued back to back
    for (int i = 0; i < 7; i++) run_vec(i);

    // reset in the middle of byte1 while SCL is low
    sel = 1'b0;
    ev_q.delete();
    cmd_rw = 1'b0; cmd_dev = 7'h5A; cmd_reg = 8'h03; cmd_wdata = 8'hC5;
    cmd_valid0 = 1'b1;
    @(negedge clk);
    cmd_valid0 = 1'b0;
    repeat (193) @(negedge clk);
    check("mid busy", busy0, 1'b1);
    check("mid scl_low", scl_oe0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("abort scl_oe", scl_oe0, 1'b0);
    check("abort sda_oe", sda_oe0, 1'b0);
    check("abort busy", busy0, 1'b0);
    check("abort done", done0, 1'b0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done0 || busy0) ndone++;
    end
    check("abort quiet", ndone, 0);
    check("abort rd_data", rd_data0, 8'h00);
    check("abort ev_count", ev_q.size(), 2);
    if (ev_q.size() >= 2) begin
      check("abort ev0", ev_q[0], EV_S);
      check("abort ev1", ev_q[1], 32'hB4);
    end else begin
      check("abort ev_short", ev_q.size(), 2);
    end

    // recovery: a normal read after the abort
    run_vec(1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
